// File: rtl/uart_bus_bridge_pkg.sv
// ============================================================================
// Module      : uart_bus_bridge_pkg
// Description : Shared opcodes, reply codes and FSM state types for the
//               UART-to-bus debug bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_bus_bridge_pkg;

  localparam logic [7:0] C_OP_WRITE  = 8'h01;
  localparam logic [7:0] C_OP_READ   = 8'h02;
  localparam logic [7:0] C_OP_PING   = 8'h03;
  localparam logic [7:0] C_OP_WRNEXT = 8'h04;

  localparam logic [7:0] C_ACK = 8'h06;
  localparam logic [7:0] C_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_REQ    = 3'd3,
    ST_ACCESS = 3'd4,
    ST_REPLY  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_bus_bridge_phy.sv
// ============================================================================
// Module      : uart_bus_bridge_phy
// Description : 16x oversampling tick divider with 8N1 receiver and
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_bridge_phy
  import uart_bus_bridge_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic       tick_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o
);

  localparam int DIV_RAW = CLK_HZ / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV + 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick   = (div_q == DIV_W'(DIV - 1));
  assign tick_o = tick;

  always_ff @(posedge clk) begin
    if (rst || tick) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  logic [1:0] rx_sync_q;
  logic       rxs;

  always_ff @(posedge clk) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], rxd_i};
  end
  assign rxs = rx_sync_q[1];

  rx_state_e  rx_st_q, rx_st_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  // Start bit is re-checked 8 ticks after detection; data/stop then land mid-bit.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_o = 1'b0;
    rx_ferr_o  = 1'b0;
    if (tick) begin
      case (rx_st_q)
        RX_IDLE: begin
          if (!rxs) begin
            rx_st_d  = RX_START;
            rx_cnt_d = '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rxs, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == 4'd15) begin
            rx_st_d    = RX_IDLE;
            rx_valid_o = rxs;
            rx_ferr_o  = !rxs;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        default: rx_st_d = RX_IDLE;
      endcase
    end
  end

  assign rx_data_o = rx_sh_q;

  logic       tx_busy_q;
  logic [9:0] tx_sh_q;
  logic [3:0] tx_bit_q;
  logic [3:0] tx_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start_i) begin
        tx_busy_q <= 1'b1;
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_bit_q  <= '0;
        tx_cnt_q  <= '0;
      end
    end else if (tick) begin
      if (tx_cnt_q == 4'd15) begin
        tx_cnt_q <= '0;
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
        else                  tx_bit_q  <= tx_bit_q + 4'd1;
      end else begin
        tx_cnt_q <= tx_cnt_q + 4'd1;
      end
    end
  end

  // Line is forced high whenever no frame is in flight, including after reset.
  assign txd_o     = !tx_busy_q | tx_sh_q[0];
  assign tx_busy_o = tx_busy_q;

endmodule

`default_nettype wire

// File: rtl/uart_bus_bridge.sv
// ============================================================================
// Module      : uart_bus_bridge
// Description : UART command-packet bridge acting as a data-bus master.
//               Optional macro UART_BUS_BRIDGE_AUTOINC_EN enables WRNEXT (0x04).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  output logic        m_req,
  input  logic        m_gnt,
  output logic        m_de,
  output logic        m_drw,
  output logic [31:0] m_addr,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  output logic        err
);

  localparam int TMO_TICKS = TIMEOUT_BITS * 16;
  localparam int TMO_W     = $clog2(TMO_TICKS + 1);

  logic       tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  uart_bus_bridge_phy #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_phy (
    .clk        (clk),
    .rst        (rst),
    .rxd_i      (rxd),
    .txd_o      (txd),
    .tick_o     (tick),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .tx_data_i  (tx_data),
    .tx_start_i (tx_start),
    .tx_busy_o  (tx_busy)
  );

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        left_q, left_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       last_addr_q, last_addr_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [31:0]       m_dout_q, m_dout_d;
  logic              m_drw_q, m_drw_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      left_q      <= '0;
      tmo_q       <= '0;
      last_addr_q <= '0;
      m_addr_q    <= '0;
      m_dout_q    <= '0;
      m_drw_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      left_q      <= left_d;
      tmo_q       <= tmo_d;
      last_addr_q <= last_addr_d;
      m_addr_q    <= m_addr_d;
      m_dout_q    <= m_dout_d;
      m_drw_q     <= m_drw_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    left_d      = left_q;
    tmo_d       = tmo_q;
    last_addr_d = last_addr_q;
    m_addr_d    = m_addr_q;
    m_dout_d    = m_dout_q;
    m_drw_d     = m_drw_q;
    err_d       = rx_ferr;
    tx_start    = 1'b0;
    tx_data     = C_ACK;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          op_d  = rx_data;
          cnt_d = '0;
          tmo_d = '0;
          case (rx_data)
            C_OP_WRITE, C_OP_READ: state_d = ST_ADDR;
            C_OP_PING: begin
              state_d  = ST_REPLY;
              tx_start = 1'b1;
              tx_data  = C_ACK;
              left_d   = '0;
            end
`ifdef UART_BUS_BRIDGE_AUTOINC_EN
            C_OP_WRNEXT: begin
              state_d = ST_DATA;
              addr_d  = last_addr_q + 32'd4;
            end
`endif
            default: begin
              state_d  = ST_REPLY;
              tx_start = 1'b1;
              tx_data  = C_NAK;
              left_d   = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end

      // A byte completing in the expiry cycle is taken, so it is checked first.
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          tmo_d  = '0;
          if (cnt_q == 2'd3) state_d = (op_q == C_OP_READ) ? ST_REQ : ST_DATA;
        end else if (tmo_q == TMO_W'(TMO_TICKS)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (tick) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          data_d = {data_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          tmo_d  = '0;
          if (cnt_q == 2'd3) state_d = ST_REQ;
        end else if (tmo_q == TMO_W'(TMO_TICKS)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (tick) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_REQ: begin
        if (m_gnt) begin
          state_d  = ST_ACCESS;
          m_addr_d = addr_q;
          m_dout_d = data_q;
          m_drw_d  = (op_q != C_OP_READ);
        end
      end

      // Read data is only valid during this cycle, so the first reply byte goes straight out.
      ST_ACCESS: begin
        last_addr_d = m_addr_q;
        state_d     = ST_REPLY;
        tx_start    = 1'b1;
        if (m_drw_q) begin
          tx_data = C_ACK;
          left_d  = '0;
        end else begin
          tx_data = m_din[31:24];
          rdata_d = {m_din[23:0], 8'h00};
          left_d  = 2'd3;
        end
      end

      ST_REPLY: begin
        if (!tx_busy) begin
          if (left_q != 2'd0) begin
            tx_start = 1'b1;
            tx_data  = rdata_q[31:24];
            rdata_d  = {rdata_q[23:0], 8'h00};
            left_d   = left_q - 2'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign m_req  = (state_q == ST_REQ) || (state_q == ST_ACCESS);
  assign m_de   = (state_q == ST_ACCESS);
  assign m_drw  = m_drw_q;
  assign m_addr = m_addr_q;
  assign m_dout = m_dout_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
// ============================================================================
// Module      : tb_uart_bus_bridge
// Description : Self-checking bench for uart_bus_bridge (vector table plus
//               reply/bus scoreboards). Honors UART_BUS_BRIDGE_AUTOINC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_bus_bridge;

  localparam int CLK_HZ = 3200000;
  localparam int BAUD   = 100000;
  localparam int BITC   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        m_gnt = 1'b1;
  logic [31:0] m_din = '0;
  logic        txd, m_req, m_de, m_drw, err;
  logic [31:0] m_addr, m_dout;

  uart_bus_bridge #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (200)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .txd    (txd),
    .m_req  (m_req),
    .m_gnt  (m_gnt),
    .m_de   (m_de),
    .m_drw  (m_drw),
    .m_addr (m_addr),
    .m_dout (m_dout),
    .m_din  (m_din),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [71:0] pkt;
    logic [31:0] din;
    int          nrep;
    logic [31:0] rep;
    bit          has_bus;
    bit          drw;
    logic [31:0] addr;
    logic [31:0] dout;
    int          nerr;
  } vec_t;

  typedef struct packed {
    logic        drw;
    logic [31:0] addr;
    logic [31:0] dout;
  } bus_t;

  logic [7:0] exp_q[$];
  bus_t       bus_q[$];
  int         checks = 0;
  int         errors = 0;
  int         err_cnt = 0;
  bit         req_seen = 1'b0;
  vec_t       vecs[7];
  vec_t       v_after;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    rxd = stop;
    repeat (BITC) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_pkt(input logic [71:0] pkt, input int len);
    for (int i = 0; i < len; i++) send_byte(pkt[8*(len-1-i) +: 8], 1'b1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 8000) begin
      @(negedge clk);
      t++;
    end
    chk("reply_drained", 32'(exp_q.size()), 32'd0);
    repeat (3 * BITC) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    m_din    = v.din;
    base     = err_cnt;
    req_seen = 1'b0;
    for (int i = 0; i < v.nrep; i++) exp_q.push_back(v.rep[8*(v.nrep-1-i) +: 8]);
    if (v.has_bus) bus_q.push_back(bus_t'{v.drw, v.addr, v.dout});
    send_pkt(v.pkt, v.len);
    wait_drain();
    chk("bus_done", 32'(bus_q.size()), 32'd0);
    chk("err_count", 32'(err_cnt - base), 32'(v.nerr));
    chk("req_seen", 32'(req_seen), 32'(v.has_bus));
  endtask

  // Decode txd mid-bit and score each byte against the expected reply queue.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        repeat (BITC / 2) @(negedge clk);
        chk("tx_start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) @(negedge clk);
          b[i] = txd;
        end
        repeat (BITC) @(negedge clk);
        chk("tx_stop_bit", 32'(txd), 32'd1);
        chk("tx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : bus_mon
    bus_t e;
    forever begin
      @(negedge clk);
      if (m_req === 1'b1) req_seen = 1'b1;
      if (err === 1'b1) err_cnt++;
      if (m_de === 1'b1) begin
        chk("de_with_req", 32'(m_req), 32'd1);
        chk("de_expected", 32'(bus_q.size() != 0), 32'd1);
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          chk("bus_drw", 32'(m_drw), 32'(e.drw));
          chk("bus_addr", m_addr, e.addr);
          if (e.drw) chk("bus_dout", m_dout, e.dout);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  base;
    int  t;
    bit  held;

    vecs[0] = '{len:9, pkt:72'h01_00000010_DEADBEEF, din:32'h0, nrep:1, rep:32'h06,
                has_bus:1'b1, drw:1'b1, addr:32'h10, dout:32'hDEADBEEF, nerr:0};
`ifdef UART_BUS_BRIDGE_AUTOINC_EN
    vecs[1] = '{len:5, pkt:72'h04_00000001, din:32'h0, nrep:1, rep:32'h06,
                has_bus:1'b1, drw:1'b1, addr:32'h14, dout:32'h1, nerr:0};
`else
    vecs[1] = '{len:1, pkt:72'h04, din:32'h0, nrep:1, rep:32'h15,
                has_bus:1'b0, drw:1'b0, addr:32'h0, dout:32'h0, nerr:1};
`endif
    vecs[2] = '{len:5, pkt:72'h02_00000008, din:32'h12345678, nrep:4, rep:32'h12345678,
                has_bus:1'b1, drw:1'b0, addr:32'h8, dout:32'h0, nerr:0};
    vecs[3] = '{len:1, pkt:72'h7F, din:32'h0, nrep:1, rep:32'h15,
                has_bus:1'b0, drw:1'b0, addr:32'h0, dout:32'h0, nerr:1};
    vecs[4] = '{len:1, pkt:72'h03, din:32'h0, nrep:1, rep:32'h06,
                has_bus:1'b0, drw:1'b0, addr:32'h0, dout:32'h0, nerr:0};
    vecs[5] = '{len:5, pkt:72'h02_FFFFFFFC, din:32'hA5A55A5A, nrep:4, rep:32'hA5A55A5A,
                has_bus:1'b1, drw:1'b0, addr:32'hFFFFFFFC, dout:32'h0, nerr:0};
    vecs[6] = '{len:9, pkt:72'h01_80000000_00000000, din:32'h0, nrep:1, rep:32'h06,
                has_bus:1'b1, drw:1'b1, addr:32'h80000000, dout:32'h0, nerr:0};
    v_after = '{len:9, pkt:72'h01_00000040_11223344, din:32'h0, nrep:1, rep:32'h06,
                has_bus:1'b1, drw:1'b1, addr:32'h40, dout:32'h11223344, nerr:0};

    repeat (4) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_de", 32'(m_de), 32'd0);
    chk("rst_m_drw", 32'(m_drw), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_dout", m_dout, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2 * BITC) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Grant held low: request must stay up with no access until the grant arrives.
    base     = err_cnt;
    m_gnt    = 1'b0;
    exp_q.push_back(8'h06);
    bus_q.push_back(bus_t'{1'b1, 32'h20, 32'hCAFEF00D});
    send_pkt(72'h01_00000020_CAFEF00D, 9);
    t = 0;
    while (m_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("gnt_req_raised", 32'(m_req), 32'd1);
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_req !== 1'b1 || m_de !== 1'b0) held = 1'b0;
    end
    chk("gnt_req_held_no_de", 32'(held), 32'd1);
    m_gnt = 1'b1;
    chk("gnt_de_not_yet", 32'(m_de), 32'd0);
    @(negedge clk);
    chk("gnt_de_next_cycle", 32'(m_de), 32'd1);
    chk("gnt_req_in_access", 32'(m_req), 32'd1);
    @(negedge clk);
    chk("gnt_de_one_cycle", 32'(m_de), 32'd0);
    chk("gnt_req_dropped", 32'(m_req), 32'd0);
    wait_drain();
    chk("gnt_bus_done", 32'(bus_q.size()), 32'd0);
    chk("gnt_err_count", 32'(err_cnt - base), 32'd0);

    // Inter-byte timeout inside a packet.
    base     = err_cnt;
    req_seen = 1'b0;
    send_pkt(72'h01_00_00, 3);
    t = 0;
    while (err_cnt == base && t < 8000) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_err", 32'(err_cnt - base), 32'd1);
    chk("timeout_not_early", 32'(t > 6000), 32'd1);
    repeat (4 * BITC) @(negedge clk);
    chk("timeout_no_req", 32'(req_seen), 32'd0);
    chk("timeout_single_err", 32'(err_cnt - base), 32'd1);
    run_vec(v_after);

    // Framing error: byte dropped with an err pulse, bridge stays usable.
    base = err_cnt;
    send_byte(8'hA5, 1'b0);
    repeat (4 * BITC) @(negedge clk);
    chk("ferr_err", 32'(err_cnt - base), 32'd1);
    run_vec(vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
